// File: rtl/write_burst_aligner_pkg.sv
// Shared helpers for the store-path burst aligner.
// Lane geometry derived from the bus width.
package write_burst_aligner_pkg;

    function automatic int lane_bytes(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int lane_idx_w(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/write_burst_aligner_shifter.sv
// Combinational byte-lane shifter: {data,strb} moved up by s lanes,
// split into the in-beat half and the spill (carry) half.
module burst_lane_shifter
    import write_burst_aligner_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0]                 data,
    input  logic [lane_bytes(DATA_WIDTH)-1:0]     strb,
    input  logic [lane_idx_w(DATA_WIDTH)-1:0]     shamt,
    output logic [DATA_WIDTH-1:0]                 shifted,
    output logic [DATA_WIDTH-1:0]                 carry,
    output logic [lane_bytes(DATA_WIDTH)-1:0]     shifted_strb,
    output logic [lane_bytes(DATA_WIDTH)-1:0]     carry_strb
);

    localparam int B = lane_bytes(DATA_WIDTH);

    logic [2*DATA_WIDTH-1:0] wide_d;
    logic [2*B-1:0]          wide_s;

    assign wide_d = {{DATA_WIDTH{1'b0}}, data} << {shamt, 3'b000};
    assign wide_s = {{B{1'b0}}, strb} << shamt;

    assign shifted      = wide_d[DATA_WIDTH-1:0];
    assign carry        = wide_d[2*DATA_WIDTH-1:DATA_WIDTH];
    assign shifted_strb = wide_s[B-1:0];
    assign carry_strb   = wide_s[2*B-1:B];

endmodule

// File: rtl/write_burst_aligner.sv
// Shifts a packed store stream onto unaligned byte lanes, emitting
// strobed write beats plus a trailing flush beat for spilled bytes.
module write_burst_aligner
    import write_burst_aligner_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_valid,
    output logic                              i_ready,
    input  logic                              i_start,
    input  logic                              i_end,
    input  logic [DATA_WIDTH-1:0]             i_data,
    input  logic [lane_bytes(DATA_WIDTH)-1:0] i_strb,
    input  logic [lane_idx_w(DATA_WIDTH)-1:0] i_shamt,
    output logic                              o_valid,
    input  logic                              o_ready,
    output logic                              o_start,
    output logic                              o_end,
    output logic [DATA_WIDTH-1:0]             o_data,
    output logic [lane_bytes(DATA_WIDTH)-1:0] o_strb,
    output logic                              o_idle
);

    localparam int B  = lane_bytes(DATA_WIDTH);
    localparam int SW = lane_idx_w(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_FLUSH
    } state_t;

    state_t                state;
    logic [SW-1:0]         shamt_r;
    logic [SW-1:0]         s;
    logic [DATA_WIDTH-1:0] carry_r;
    logic [B-1:0]          cstrb_r;

    logic [DATA_WIDTH-1:0] sh_d;
    logic [DATA_WIDTH-1:0] carry_n;
    logic [B-1:0]          sh_s;
    logic [B-1:0]          cstrb_n;
    logic                  spill;
    logic                  accept;
    logic                  data_beat;

    assign s = (state == S_IDLE) ? i_shamt : shamt_r;

    burst_lane_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shift (
        .data         (i_data),
        .strb         (i_strb),
        .shamt        (s),
        .shifted      (sh_d),
        .carry        (carry_n),
        .shifted_strb (sh_s),
        .carry_strb   (cstrb_n)
    );

    assign spill     = |cstrb_n;
    assign accept    = i_valid && i_ready;
    assign data_beat = accept && ((state == S_BURST) || i_start);
    assign o_idle    = (state == S_IDLE) && !(i_valid && i_start);

    always_comb begin
        i_ready = o_ready;
        o_valid = 1'b0;
        o_start = 1'b0;
        o_end   = 1'b0;
        o_data  = sh_d | carry_r;
        o_strb  = sh_s | cstrb_r;
        unique case (state)
            S_IDLE: begin
                o_valid = i_valid && i_start;
                o_start = i_valid && i_start;
                o_end   = i_valid && i_start && i_end && !spill;
            end
            S_BURST: begin
                o_valid = i_valid;
                o_end   = i_valid && i_end && !spill;
            end
            S_FLUSH: begin
                i_ready = 1'b0;
                o_valid = 1'b1;
                o_end   = 1'b1;
                o_data  = carry_r;
                o_strb  = cstrb_r;
            end
            default: begin
                o_valid = 1'b0;
            end
        endcase
    end

    // Carry is cleared whenever the burst closes so nothing ORs into the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            shamt_r <= '0;
            carry_r <= '0;
            cstrb_r <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_BURST: begin
                    if (data_beat) begin
                        if (state == S_IDLE) shamt_r <= i_shamt;
                        if (i_end && !spill) begin
                            state   <= S_IDLE;
                            carry_r <= '0;
                            cstrb_r <= '0;
                        end else begin
                            state   <= i_end ? S_FLUSH : S_BURST;
                            carry_r <= carry_n;
                            cstrb_r <= cstrb_n;
                        end
                    end
                end
                S_FLUSH: begin
                    if (o_ready) begin
                        state   <= S_IDLE;
                        carry_r <= '0;
                        cstrb_r <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
